toggle_pulse_gen: RTL and testbench

TOGGLE_PULSE_GEN -- requirements
Module: toggle_pulse_gen

---
 rtl/toggle_pkg.sv | 16 +
 rtl/sync_2ff.sv | 29 ++
 rtl/toggle_pulse_gen.sv | 129 ++++++++++++
 tb/tb_toggle_pulse_gen.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/toggle_pkg.sv
// Shared types and helpers for the debounced toggle-pulse generator.
package toggle_pkg;

   typedef enum logic [1:0] {
      LOW       = 2'd0,
      RISE_WAIT = 2'd1,
      HIGH      = 2'd2,
      FALL_WAIT = 2'd3
   } state_e;

   // Counter width for a compare value of n-1; always at least one bit.
   function automatic int cnt_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, reset to 0.
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic dout
);

   logic s1_q, s1_d;
   logic s2_q, s2_d;

   always_comb begin
      s1_d = din;
      s2_d = s1_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= s1_d;
         s2_q <= s2_d;
      end
   end

   assign dout = s2_q;

endmodule

// File: rtl/toggle_pulse_gen.sv
// Debounces a raw button and emits a one-cycle toggle-enable pulse on the
// accepted press (or release), with optional auto-repeat while held.
//
//   state     | meaning
//   ----------+-----------------------------------------------
//   LOW       | button accepted as released, level = 0
//   RISE_WAIT | synchronized input is 1, qualifying a press
//   HIGH      | button accepted as pressed, level = 1
//   FALL_WAIT | synchronized input is 0, qualifying a release
module toggle_pulse_gen
   import toggle_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES  = 16,
   parameter int REPEAT_CYCLES    = 0,
   parameter int PULSE_ON_RELEASE = 0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_in,
   output logic t,
   output logic level
);

   localparam int DW = cnt_width(DEBOUNCE_CYCLES);
   localparam int RW = cnt_width(REPEAT_CYCLES);
   localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_CYCLES - 1);
   localparam bit REPEAT_EN  = (REPEAT_CYCLES > 0) && (PULSE_ON_RELEASE == 0);
   localparam bit PRESS_PULSE = (PULSE_ON_RELEASE == 0);

   logic btn_s;

   state_e          state_q, state_d;
   logic [DW-1:0]   db_cnt_q, db_cnt_d;
   logic [RW-1:0]   rpt_cnt_q, rpt_cnt_d;
   logic            level_q, level_d;
   logic            t_q, t_d;

   sync_2ff u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (btn_in),
      .dout  (btn_s)
   );

   // Counters only advance below their compare value, so they saturate
   // rather than wrap. The repeat counter defaults to clear outside HIGH.
   always_comb begin
      state_d   = state_q;
      db_cnt_d  = db_cnt_q;
      rpt_cnt_d = '0;
      level_d   = level_q;
      t_d       = 1'b0;

      case (state_q)
         LOW: begin
            db_cnt_d = '0;
            if (btn_s) state_d = RISE_WAIT;
         end

         RISE_WAIT: begin
            if (!btn_s) begin
               state_d  = LOW;
               db_cnt_d = '0;
            end else if (db_cnt_q == DB_LAST) begin
               state_d  = HIGH;
               db_cnt_d = '0;
               level_d  = 1'b1;
               t_d      = PRESS_PULSE;
            end else begin
               db_cnt_d = db_cnt_q + 1'b1;
            end
         end

         HIGH: begin
            db_cnt_d = '0;
            if (!btn_s) begin
               state_d = FALL_WAIT;
            end else if (REPEAT_EN) begin
               if (rpt_cnt_q == RP_LAST) begin
                  t_d = 1'b1;
               end else begin
                  rpt_cnt_d = rpt_cnt_q + 1'b1;
               end
            end
         end

         FALL_WAIT: begin
            if (btn_s) begin
               state_d  = HIGH;
               db_cnt_d = '0;
            end else if (db_cnt_q == DB_LAST) begin
               state_d  = LOW;
               db_cnt_d = '0;
               level_d  = 1'b0;
               t_d      = !PRESS_PULSE;
            end else begin
               db_cnt_d = db_cnt_q + 1'b1;
            end
         end

         default: begin
            state_d  = LOW;
            db_cnt_d = '0;
            level_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= LOW;
         db_cnt_q  <= '0;
         rpt_cnt_q <= '0;
         level_q   <= 1'b0;
         t_q       <= 1'b0;
      end else begin
         state_q   <= state_d;
         db_cnt_q  <= db_cnt_d;
         rpt_cnt_q <= rpt_cnt_d;
         level_q   <= level_d;
         t_q       <= t_d;
      end
   end

   assign t     = t_q;
   assign level = level_q;

endmodule

// File: tb/tb_toggle_pulse_gen.sv
// Self-checking bench: three parameterisations driven by one button,
// compared every cycle against a run-length reference model.
module tb_toggle_pulse_gen;

   localparam int D = 4;
   localparam int NI = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic btn_in = 1'b0;
   logic [NI-1:0] t_v;
   logic [NI-1:0] lvl_v;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int mark_cyc = 0;

   int  p_rpt [NI] = '{0, 8, 0};
   bit  p_rel [NI] = '{1'b0, 1'b0, 1'b1};

   bit  s1m, s2m;
   bit  m_lvl [NI];
   bit  m_t   [NI];
   int  m_run [NI];
   int  m_h   [NI];
   bit  prev_t [NI];
   int  npulse [NI];
   int  first_pulse [NI];

   always #5 clk = ~clk;

   toggle_pulse_gen #(.DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(0), .PULSE_ON_RELEASE(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .t(t_v[0]), .level(lvl_v[0]));
   toggle_pulse_gen #(.DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(8), .PULSE_ON_RELEASE(0)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .t(t_v[1]), .level(lvl_v[1]));
   toggle_pulse_gen #(.DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(0), .PULSE_ON_RELEASE(1)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .t(t_v[2]), .level(lvl_v[2]));

   task automatic model_reset();
      s1m = 1'b0;
      s2m = 1'b0;
      for (int i = 0; i < NI; i++) begin
         m_lvl[i] = 1'b0;
         m_t[i]   = 1'b0;
         m_run[i] = 0;
         m_h[i]   = 0;
      end
   endtask

   // A new level is accepted once the synchronized input has disagreed with
   // it on D+1 consecutive edges; any agreeing edge restarts the run.
   task automatic model_step(input int i, input bit s2);
      m_t[i] = 1'b0;
      if (s2 != m_lvl[i]) begin
         m_h[i] = 0;
         m_run[i]++;
         if (m_run[i] == D + 1) begin
            m_lvl[i] = s2;
            m_run[i] = 0;
            m_t[i]   = (s2 != p_rel[i]);
         end
      end else if (m_run[i] > 0) begin
         m_run[i] = 0;
         m_h[i]   = 0;
      end else if (m_lvl[i] && p_rpt[i] > 0 && !p_rel[i]) begin
         if (m_h[i] == p_rpt[i] - 1) begin
            m_t[i] = 1'b1;
            m_h[i] = 0;
         end else begin
            m_h[i]++;
         end
      end
   endtask

   task automatic compare_all(input string tag);
      for (int i = 0; i < NI; i++) begin
         checks++;
         assert (t_v[i] === m_t[i]) else begin
            errors++;
            $error("FAIL %s t dut%0d cyc %0d got %b exp %b", tag, i, cyc, t_v[i], m_t[i]);
         end
         checks++;
         assert (lvl_v[i] === m_lvl[i]) else begin
            errors++;
            $error("FAIL %s level dut%0d cyc %0d got %b exp %b", tag, i, cyc, lvl_v[i], m_lvl[i]);
         end
         checks++;
         assert (!(t_v[i] === 1'b1 && prev_t[i])) else begin
            errors++;
            $error("FAIL %s t_consecutive dut%0d cyc %0d got 11 exp not 11", tag, i, cyc);
         end
      end
   endtask

   task automatic tick(input string tag);
      @(posedge clk);
      if (!rst_n) begin
         model_reset();
      end else begin
         for (int i = 0; i < NI; i++) model_step(i, s2m);
         s2m = s1m;
         s1m = btn_in;
      end
      cyc++;
      @(negedge clk);
      compare_all(tag);
      for (int i = 0; i < NI; i++) begin
         prev_t[i] = (t_v[i] === 1'b1);
         if (t_v[i] === 1'b1) begin
            npulse[i]++;
            if (first_pulse[i] < 0) first_pulse[i] = cyc - mark_cyc;
         end
      end
   endtask

   task automatic mark();
      mark_cyc = cyc;
      for (int i = 0; i < NI; i++) begin
         npulse[i] = 0;
         first_pulse[i] = -1;
      end
   endtask

   task automatic run(input int n, input string tag);
      for (int k = 0; k < n; k++) tick(tag);
   endtask

   task automatic check_int(input string tag, input int got, input int exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %0d exp %0d", tag, got, exp);
      end
   endtask

   task automatic apply_reset(input int n, input string tag);
      rst_n = 1'b0;
      model_reset();
      #1;
      compare_all(tag);
      for (int i = 0; i < NI; i++) prev_t[i] = 1'b0;
      run(n, tag);
      rst_n = 1'b1;
   endtask

   initial begin
      model_reset();
      mark();
      for (int i = 0; i < NI; i++) prev_t[i] = 1'b0;

      // Reset state
      @(negedge clk);
      apply_reset(3, "reset");
      run(3, "post_reset");

      // Clean press and release
      btn_in = 1'b1;
      mark();
      run(14, "clean_press");
      check_int("clean_press_latency", first_pulse[0], D + 3);
      check_int("clean_press_count", npulse[0], 1);
      check_int("clean_press_rel_mode_count", npulse[2], 0);
      btn_in = 1'b0;
      mark();
      run(14, "clean_release");
      check_int("clean_release_count", npulse[0], 0);
      check_int("release_mode_latency", first_pulse[2], D + 3);
      check_int("release_mode_count", npulse[2], 1);

      // Bounce 1,0,1 then hold
      btn_in = 1'b1;
      tick("bounce");
      btn_in = 1'b0;
      tick("bounce");
      btn_in = 1'b1;
      mark();
      run(14, "bounce");
      check_int("bounce_latency", first_pulse[0], D + 3);
      check_int("bounce_count", npulse[0], 1);
      btn_in = 1'b0;
      run(14, "bounce_release");

      // Glitch shorter than the debounce window
      btn_in = 1'b1;
      mark();
      run(3, "glitch");
      btn_in = 1'b0;
      run(14, "glitch");
      check_int("glitch_count0", npulse[0], 0);
      check_int("glitch_count1", npulse[1], 0);
      check_int("glitch_level", int'(lvl_v[0]), 0);

      // Long hold: auto-repeat on dut1
      btn_in = 1'b1;
      mark();
      run(44, "repeat_hold");
      btn_in = 1'b0;
      run(24, "repeat_release");
      check_int("repeat_count", npulse[1], 5);
      check_int("repeat_plain_count", npulse[0], 1);
      check_int("repeat_rel_mode_count", npulse[2], 1);

      // Reset mid-debounce with the button held through reset
      btn_in = 1'b1;
      mark();
      run(5, "mid_debounce");
      apply_reset(3, "mid_debounce_reset");
      mark();
      run(14, "after_reset");
      check_int("reset_requalify_latency", first_pulse[0], D + 3);
      check_int("reset_requalify_count", npulse[0], 1);
      btn_in = 1'b0;
      run(14, "after_reset_release");

      // Randomized holds with occasional reset
      for (int seg = 0; seg < 400; seg++) begin
         btn_in = $urandom_range(0, 1);
         run($urandom_range(1, 12), "random");
         if ($urandom_range(0, 49) == 0) apply_reset($urandom_range(1, 3), "random_reset");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
